// File: rtl/yolo_flow_ctrl_if.sv
// Handshake bundle between the frame flow controller and its FIFO/top/consumer environment.
// YOLO_FLOW_PERF_EN adds the stall_cnt performance counter to the bundle.
interface yolo_flow_ctrl_if #(
    parameter int CNT_W = 20
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] frame_len;
    logic             in_empty;
    logic             in_deq;
    logic             core_valid;
    logic             out_enq;
    logic             out_deq;
    logic             busy;
    logic             frame_done;
    logic             aborted;
    logic             err;
    logic [CNT_W-1:0] issued_cnt;
`ifdef YOLO_FLOW_PERF_EN
    logic [31:0]      stall_cnt;

    modport master (
        input  start, abort, frame_len, in_empty, out_enq, out_deq,
        output in_deq, core_valid, busy, frame_done, aborted, err, issued_cnt, stall_cnt
    );
    modport slave (
        output start, abort, frame_len, in_empty, out_enq, out_deq,
        input  in_deq, core_valid, busy, frame_done, aborted, err, issued_cnt, stall_cnt
    );
`else
    modport master (
        input  start, abort, frame_len, in_empty, out_enq, out_deq,
        output in_deq, core_valid, busy, frame_done, aborted, err, issued_cnt
    );
    modport slave (
        output start, abort, frame_len, in_empty, out_enq, out_deq,
        input  in_deq, core_valid, busy, frame_done, aborted, err, issued_cnt
    );
`endif
endinterface

// File: rtl/yolo_flow_ctrl.sv
// Credit-based frame sequencer for input FIFO -> YOLOv3-Tiny top -> output FIFO.
// Optional YOLO_FLOW_PERF_EN adds a saturating stall counter (stall_cnt).
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing words while credit, input data and frame length allow
// DRAIN | all words issued, waiting for top to return in-flight words
// DONE  | frame_done pulse, back to IDLE
// ABRT  | issue blocked, waiting for in-flight words, then aborted pulse
module yolo_flow_ctrl #(
    parameter int OUT_DEPTH = 16,
    parameter int CNT_W     = 20,
    parameter int INFL_W    = 8
) (
    input logic              Clk,
    input logic              Rst_N,
    yolo_flow_ctrl_if.master bus
);
    localparam int CR_W = $clog2(OUT_DEPTH + 1);
    localparam logic [CR_W-1:0] CR_FULL = CR_W'(OUT_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ABRT  = 3'd4
    } state_t;

    state_t            state_q;
    logic [CR_W-1:0]   credit_q, credit_d;
    logic [INFL_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  issued_q;
    logic              busy_q, done_q, aborted_q, err_q;
    logic              issue, credit_full, start_ok, start_bad;
    logic              credit_err, infl_err;

    assign credit_full = (credit_q == CR_FULL);

    assign issue = (state_q == S_RUN) & ~bus.in_empty & (credit_q != '0) &
                   (issued_q != len_q) & ~bus.abort;

    assign start_ok  = (state_q == S_IDLE) & bus.start & ~bus.abort & (bus.frame_len != '0);
    assign start_bad = (state_q == S_IDLE) & bus.start & ~bus.abort & (bus.frame_len == '0);

    // A dequeue with every slot already credited is a consumer underflow: flag it, keep credit.
    always_comb begin
        credit_d   = credit_q;
        credit_err = bus.out_deq & credit_full;
        if (issue && !bus.out_deq) begin
            credit_d = credit_q - CR_W'(1);
        end else if (!issue && bus.out_deq && !credit_full) begin
            credit_d = credit_q + CR_W'(1);
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        infl_err   = bus.out_enq & ~issue & (inflight_q == '0);
        if (issue && !bus.out_enq) begin
            inflight_d = inflight_q + INFL_W'(1);
        end else if (!issue && bus.out_enq && inflight_q != '0) begin
            inflight_d = inflight_q - INFL_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            credit_q   <= CR_FULL;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
            err_q      <= err_q | start_bad | credit_err | infl_err;
        end
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            issued_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (issue) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        len_q    <= bus.frame_len;
                        issued_q <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state_q <= S_ABRT;
                    end else if (issued_q == len_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (inflight_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (bus.abort) begin
                        state_q <= S_ABRT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_ABRT: begin
                    // Look at the updated count so the pulse follows the last return by one cycle.
                    if (inflight_d == '0) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef YOLO_FLOW_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (state_q == S_RUN && !issue && issued_q != len_q && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

    assign bus.in_deq     = issue;
    assign bus.core_valid = issue;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.err        = err_q;
    assign bus.issued_cnt = issued_q;
endmodule

// File: tb/tb_yolo_flow_ctrl.sv
// Directed bench for yolo_flow_ctrl with a 3-cycle top pipeline and output FIFO occupancy model.
module tb_yolo_flow_ctrl;
    logic Clk;
    logic Rst_N;

    yolo_flow_ctrl_if #(.CNT_W(20)) bus ();

    yolo_flow_ctrl #(.OUT_DEPTH(16), .CNT_W(20), .INFL_W(8)) dut (
        .Clk  (Clk),
        .Rst_N(Rst_N),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int   n_chk, n_fail;
    int   n_issue, n_core, n_done, n_abort;
    logic [2:0] pipe;
    int   fcnt;
    bit   deq_en, deq_force;
    int   deq_budget;

    typedef struct {
        int len;
        int done_cyc;
    } frame_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        bit s_issue, s_core, s_enq, s_deq;
        bus.out_enq = pipe[2];
        bus.out_deq = deq_force || ((deq_en || deq_budget > 0) && fcnt > 0);
        #1;
        s_issue = bus.in_deq;
        s_core  = bus.core_valid;
        s_enq   = bus.out_enq;
        s_deq   = bus.out_deq;
        if (s_issue) n_issue++;
        if (s_core)  n_core++;
        @(posedge Clk);
        pipe = {pipe[1:0], s_issue};
        if (s_deq && fcnt > 0) fcnt--;
        if (s_deq && deq_budget > 0) deq_budget--;
        if (s_enq) fcnt++;
        #1;
        if (bus.frame_done) n_done++;
        if (bus.aborted)    n_abort++;
    endtask

    task automatic start_frame(input int len);
        bus.frame_len = 20'(len);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Runs until busy drops; done_cyc is the cycle (start cycle = 0) where frame_done was seen.
    task automatic run_to_idle(input int max, output int done_cyc);
        done_cyc = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (bus.frame_done && done_cyc < 0) done_cyc = k + 1;
            if (!bus.busy) break;
        end
    endtask

    task automatic do_reset();
        Rst_N = 1'b0;
        #1;
        pipe = '0;
        fcnt = 0;
        #1;
        Rst_N = 1'b1;
    endtask

    frame_vec_t fv[5];
    int d0, dc, i0, s0;
    int abort_k;

    initial begin
        n_chk = 0; n_fail = 0;
        n_issue = 0; n_core = 0; n_done = 0; n_abort = 0;
        pipe = '0; fcnt = 0; deq_en = 1'b0; deq_force = 1'b0; deq_budget = 0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.frame_len = '0;
        bus.in_empty = 1'b0; bus.out_enq = 1'b0; bus.out_deq = 1'b0;
        Rst_N = 1'b0;
        // Last issue at cycle L, last return at L+3, in-flight clear at L+4, frame_done at L+5.
        fv[0] = '{len: 1,  done_cyc: 6};
        fv[1] = '{len: 4,  done_cyc: 9};
        fv[2] = '{len: 3,  done_cyc: 8};
        fv[3] = '{len: 16, done_cyc: 21};
        fv[4] = '{len: 20, done_cyc: 25};

        #12;
        Rst_N = 1'b1;
        #1;
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_err",    32'(bus.err), 0);
        chk("rst_issued", 32'(bus.issued_cnt), 0);
        chk("rst_done",   32'(bus.frame_done), 0);
        chk("rst_abort",  32'(bus.aborted), 0);
        chk("rst_in_deq", 32'(bus.in_deq), 0);

        deq_en = 1'b1;
        foreach (fv[i]) begin
            n_issue = 0; n_core = 0; d0 = n_done;
            start_frame(fv[i].len);
            chk("frame_busy", 32'(bus.busy), 1);
            run_to_idle(80, dc);
            chk("frame_done_cycle", 32'(dc), 32'(fv[i].done_cyc));
            chk("frame_done_count", 32'(n_done - d0), 1);
            chk("frame_issues",     32'(n_issue), 32'(fv[i].len));
            chk("frame_core_valid", 32'(n_core), 32'(fv[i].len));
            chk("frame_issued_cnt", 32'(bus.issued_cnt), 32'(fv[i].len));
            chk("frame_err",        32'(bus.err), 0);
            chk("frame_idle",       32'(bus.busy), 0);
        end

        // Backpressure: no consumer, only the 16 credits allow issue.
        deq_en = 1'b0; n_issue = 0; d0 = n_done;
        start_frame(20);
        for (int k = 0; k < 30; k++) tick();
        chk("bp_issues_16", 32'(n_issue), 16);
        chk("bp_stalled",   32'(bus.in_deq), 0);
        chk("bp_busy",      32'(bus.busy), 1);
        deq_budget = 4;
        run_to_idle(60, dc);
        chk("bp_issues_20", 32'(n_issue), 20);
        chk("bp_done",      32'(n_done - d0), 1);
        chk("bp_err",       32'(bus.err), 0);
        deq_en = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("bp_drain_err", 32'(bus.err), 0);

        // Starved input in the middle of a frame.
        n_issue = 0; d0 = n_done;
        start_frame(10);
        for (int k = 0; k < 10 && n_issue < 3; k++) tick();
`ifdef YOLO_FLOW_PERF_EN
        s0 = int'(bus.stall_cnt);
`endif
        bus.in_empty = 1'b1;
        i0 = n_issue;
        for (int k = 0; k < 10; k++) tick();
        chk("starve_no_deq", 32'(n_issue - i0), 0);
`ifdef YOLO_FLOW_PERF_EN
        chk("starve_stall_cnt", bus.stall_cnt - 32'(s0), 10);
`endif
        bus.in_empty = 1'b0;
        run_to_idle(60, dc);
        chk("starve_issues", 32'(n_issue), 10);
        chk("starve_done",   32'(n_done - d0), 1);

        // Abort after 7 issues with 3 words inside the top.
        n_issue = 0; d0 = n_done; i0 = n_abort;
        start_frame(100);
        for (int k = 0; k < 20 && n_issue < 7; k++) tick();
        bus.abort = 1'b1;
        #1;
        chk("abort_blocks_issue", 32'(bus.in_deq), 0);
        tick();
        bus.abort = 1'b0;
        abort_k = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.aborted && abort_k < 0) abort_k = k;
        end
        chk("abort_pulse_cycle", 32'(abort_k), 2);
        chk("abort_pulse_count", 32'(n_abort - i0), 1);
        chk("abort_no_done",     32'(n_done - d0), 0);
        chk("abort_issues",      32'(n_issue), 7);
        chk("abort_idle",        32'(bus.busy), 0);
        chk("abort_err",         32'(bus.err), 0);

        // Start and abort together: abort wins.
        bus.abort = 1'b1;
        start_frame(5);
        bus.abort = 1'b0;
        tick();
        chk("start_abort_idle", 32'(bus.busy), 0);
        chk("start_abort_err",  32'(bus.err), 0);

        // Asynchronous reset in the middle of RUN.
        n_issue = 0;
        start_frame(20);
        for (int k = 0; k < 10 && n_issue < 5; k++) tick();
        Rst_N = 1'b0;
        #1;
        chk("arst_busy",   32'(bus.busy), 0);
        chk("arst_issued", 32'(bus.issued_cnt), 0);
        chk("arst_in_deq", 32'(bus.in_deq), 0);
        pipe = '0; fcnt = 0;
        tick();
        Rst_N = 1'b1;
        n_issue = 0; d0 = n_done;
        start_frame(2);
        run_to_idle(40, dc);
        chk("arst_frame_cycle",  32'(dc), 7);
        chk("arst_frame_done",   32'(n_done - d0), 1);
        chk("arst_frame_issued", 32'(bus.issued_cnt), 2);
        chk("arst_frame_err",    32'(bus.err), 0);

        // Zero-length start is an error and does not leave IDLE.
        start_frame(0);
        tick();
        chk("zero_len_idle", 32'(bus.busy), 0);
        chk("zero_len_err",  32'(bus.err), 1);

        // Credit underflow: dequeue with all credits home must not add a credit.
        do_reset();
        #1;
        chk("reset_clears_err", 32'(bus.err), 0);
        deq_force = 1'b1;
        tick();
        deq_force = 1'b0;
        chk("underflow_err", 32'(bus.err), 1);
        deq_en = 1'b0; n_issue = 0;
        start_frame(20);
        for (int k = 0; k < 30; k++) tick();
        chk("underflow_credit_16", 32'(n_issue), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
